decoder_2x4_pipe: RTL and testbench

//  Registered binary-to-one-hot decoder, the receive-side counterpart of the 4x2 encoder.

---
 rtl/decoder_2x4_pipe.sv | 119 +++++++++++
 tb/tb_decoder_2x4_pipe.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/decoder_2x4_pipe.sv
// Registered N-to-2**N one-hot decoder with valid/ready on both sides and a 2-entry skid buffer.
// Optional macro DEC_COUNT_EN adds a saturating accepted-transfer counter on port dec_count.
module decoder_2x4_pipe #(
    parameter int N       = 2,
    parameter int COUNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_code,
    input  logic             in_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2**N-1:0]  out_onehot
`ifdef DEC_COUNT_EN
    ,
    output logic [COUNT_W-1:0] dec_count
`endif
);

    localparam int W = 2**N;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   main_q, main_d;
    logic [W-1:0]   skid_q, skid_d;
    logic [W-1:0]   word;
    logic           in_xfer;
    logic           out_xfer;

    // Ready depends only on registered state, never on out_ready.
    assign in_ready   = !rst && (state_q != FULL);
    assign out_valid  = (state_q != EMPTY);
    assign out_onehot = main_q;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        word = '0;
        if (in_en) begin
            word[in_code] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_d  = word;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = word;
                end else if (in_xfer) begin
                    skid_d  = word;
                    state_d = FULL;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef DEC_COUNT_EN
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    // Saturates at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (in_xfer && (cnt_q != {COUNT_W{1'b1}})) begin
            cnt_d = cnt_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign dec_count = cnt_q;
`endif

endmodule

// File: tb/tb_decoder_2x4_pipe.sv
// Directed and randomized self-checking bench for decoder_2x4_pipe (N=2).
module tb_decoder_2x4_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_code;
    logic       in_en;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_onehot;
`ifdef DEC_COUNT_EN
    logic [3:0] dec_count;
`endif

    int checks;
    int errors;

    decoder_2x4_pipe #(
        .N(2),
        .COUNT_W(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_en      (in_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot)
`ifdef DEC_COUNT_EN
        ,
        .dec_count  (dec_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] q[$];
    int sent;
    int cyc;
    logic [3:0] w;

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = 2'd0;
        in_en     = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_onehot", 32'(out_onehot), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_ready", 32'(in_ready), 32'd1);

        // Streaming 0..3 with out_ready high
        out_ready = 1'b1;
        in_en     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_code  = 2'(i);
            step();
            chk("strm_valid", 32'(out_valid), 32'd1);
            chk("strm_onehot", 32'(out_onehot), 32'd1 << i);
        end
        in_valid = 1'b0;
        step();
        chk("strm_drain", 32'(out_valid), 32'd0);
        chk("strm_hold", 32'(out_onehot), 32'h8);

        // Enable
        in_valid = 1'b1;
        in_code  = 2'd2;
        in_en    = 1'b0;
        step();
        chk("en0_valid", 32'(out_valid), 32'd1);
        chk("en0_onehot", 32'(out_onehot), 32'h0);
        in_en = 1'b1;
        step();
        chk("en1_onehot", 32'(out_onehot), 32'h4);
        in_valid = 1'b0;
        step();
        chk("en_drain", 32'(out_valid), 32'd0);

        // Backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 2'd3;
        step();
        chk("bp_one_ready", 32'(in_ready), 32'd1);
        chk("bp_one_onehot", 32'(out_onehot), 32'h8);
        in_code = 2'd1;
        step();
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        chk("bp_full_onehot", 32'(out_onehot), 32'h8);
        in_code = 2'd0;
        step();
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_onehot", 32'(out_onehot), 32'h8);
        chk("bp_hold_ready", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_rel1_onehot", 32'(out_onehot), 32'h2);
        chk("bp_rel1_valid", 32'(out_valid), 32'd1);
        chk("bp_rel1_ready", 32'(in_ready), 32'd1);
        step();
        chk("bp_rel2_valid", 32'(out_valid), 32'd0);

        // Reset mid-stream clears immediately
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 2'd3;
        step();
        step();
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_onehot", 32'(out_onehot), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("mid_rel_ready", 32'(in_ready), 32'd1);
        chk("mid_rel_valid", 32'(out_valid), 32'd0);

        // Random traffic against a queue model
        sent = 0;
        cyc  = 0;
        q.delete();
        while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_code   = 2'($urandom_range(0, 3));
            in_en     = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            chk("rnd_ready", 32'(in_ready), 32'(q.size() < 2));
            chk("rnd_valid", 32'(out_valid), 32'(q.size() != 0));
            if (out_valid && out_ready) begin
                if (q.size() != 0) begin
                    chk("rnd_onehot", 32'(out_onehot), 32'(q[0]));
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                w = in_en ? (4'b0001 << in_code) : 4'b0000;
                q.push_back(w);
                sent++;
            end
            step();
            cyc++;
        end
        chk("rnd_timeout", 32'(cyc < 20000), 32'd1);
        chk("rnd_sent", 32'(sent), 32'd1000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();

`ifdef DEC_COUNT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("cnt_rst", 32'(dec_count), 32'd0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_en     = 1'b0;
        in_code   = 2'd1;
        step();
        chk("cnt_one", 32'(dec_count), 32'd1);
        for (int i = 1; i < 20; i++) begin
            in_en = i[0];
            step();
        end
        in_valid = 1'b0;
        step();
        chk("cnt_sat", 32'(dec_count), 32'd15);
        rst = 1'b1;
        #1;
        chk("cnt_clr", 32'(dec_count), 32'd0);
        step();
        rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
